// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_pkg
// Purpose  : Shared types and constants for the RV32 pipeline sequencing
//            controller: scoreboard entry layout, sequencer state encoding
//            and the empty (bubble) scoreboard entry.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

  // One scoreboard slot: an instruction that has left decode.
  typedef struct packed {
    logic       v;     // slot holds a real instruction
    logic [4:0] rd;    // destination register
    logic       we;    // writes the register file
    logic       load;  // result comes from memory
  } sb_entry_t;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } ctrl_state_e;

  // Architectural zero register; never a real producer.
  localparam logic [4:0] REG_X0 = 5'd0;

  // Scoreboard image of an injected NOP bubble.
  localparam sb_entry_t SB_NOP = '{v: 1'b0, rd: 5'd0, we: 1'b0, load: 1'b0};

  localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/hazard_match.sv
`default_nettype none
// ============================================================================
// Module   : hazard_match
// Purpose  : Compares the decoded instruction's source operands against one
//            scoreboard entry and flags a load-use hazard.
// Ports    : ent_*_i      - fields of the scoreboard entry under test
//            rs1_i/rs2_i  - decoded source register addresses
//            use_rs*_i    - operand is actually read
//            hit_o        - entry is an unforwardable load feeding an operand
// Revision : 1.0 - initial release
// ============================================================================
module hazard_match
  import hazard_ctrl_pkg::*;
(
  input  logic       ent_v_i,
  input  logic [4:0] ent_rd_i,
  input  logic       ent_we_i,
  input  logic       ent_load_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       use_rs1_i,
  input  logic       use_rs2_i,
  output logic       hit_o
);

  logic producer;
  logic consumer;

  // x0 reads as zero regardless of what was "written" to it.
  assign producer = ent_v_i & ent_we_i & ent_load_i & (ent_rd_i != REG_X0);
  assign consumer = (use_rs1_i & (rs1_i == ent_rd_i)) |
                    (use_rs2_i & (rs2_i == ent_rd_i));
  assign hit_o    = producer & consumer;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline sequencing controller beside the decode stage. Tracks
//            issued instructions in a shift-register scoreboard, stalls on
//            load-use hazards, flushes the frontend on taken redirects and
//            counts stall cycles (saturating).
// Ports    : clk_i, nrst_i          - clock, synchronous active-low reset
//            dec_*_i                - decoded instruction fields
//            redirect_i             - taken branch/jump resolved in execute
//            stall_fe_o             - hold PC, frontend and decode registers
//            bubble_o               - inject a NOP into the issue pipe
//            flush_fe_o             - invalidate frontend/decode contents
//            issue_o                - decoded instruction advances
//            stall_cnt_o            - saturating count of stall cycles
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DEPTH     = 3,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 2
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        dec_valid_i,
  input  logic [4:0]  dec_rs1_i,
  input  logic [4:0]  dec_rs2_i,
  input  logic        dec_use_rs1_i,
  input  logic        dec_use_rs2_i,
  input  logic [4:0]  dec_rd_i,
  input  logic        dec_we_i,
  input  logic        dec_load_i,
  input  logic        redirect_i,
  output logic        stall_fe_o,
  output logic        bubble_o,
  output logic        flush_fe_o,
  output logic        issue_o,
  output logic [31:0] stall_cnt_o
);

  localparam int                CNT_W      = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [CNT_W-1:0]  FLUSH_LOAD = CNT_W'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  sb_entry_t          sb_q [DEPTH];
  sb_entry_t          sb_d [DEPTH];
  ctrl_state_e        state_q;
  logic [CNT_W-1:0]   flush_cnt_q;
  logic [31:0]        stall_cnt_q;
  logic [31:0]        stall_cnt_d;
  logic [LOAD_LAT-1:0] hit_vec;
  logic               hit;

  // Only the youngest LOAD_LAT entries can still be waiting on memory data.
  for (genvar k = 0; k < LOAD_LAT; k++) begin : g_match
    hazard_match u_match (
      .ent_v_i    (sb_q[k].v),
      .ent_rd_i   (sb_q[k].rd),
      .ent_we_i   (sb_q[k].we),
      .ent_load_i (sb_q[k].load),
      .rs1_i      (dec_rs1_i),
      .rs2_i      (dec_rs2_i),
      .use_rs1_i  (dec_use_rs1_i),
      .use_rs2_i  (dec_use_rs2_i),
      .hit_o      (hit_vec[k])
    );
  end

  assign hit = |hit_vec;

  // Controls are masked while reset is held so nothing stalls or flushes.
  assign flush_fe_o  = nrst_i & (redirect_i | (state_q == ST_FLUSH));
  assign stall_fe_o  = nrst_i & dec_valid_i & hit & ~flush_fe_o;
  assign bubble_o    = stall_fe_o | flush_fe_o;
  assign issue_o     = dec_valid_i & ~stall_fe_o & ~flush_fe_o;
  assign stall_cnt_o = stall_cnt_q;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      sb_d[k] = SB_NOP;
    end
    if (issue_o) begin
      sb_d[0] = '{v: 1'b1, rd: dec_rd_i, we: dec_we_i, load: dec_load_i};
    end
    // The entry leaving slot 0 on a redirect is wrong-path; drop it.
    for (int k = 1; k < DEPTH; k++) begin
      sb_d[k] = (k == 1 && redirect_i) ? SB_NOP : sb_q[k-1];
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_fe_o && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        sb_q[k] <= SB_NOP;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        sb_q[k] <= sb_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // flush_cnt_q holds the number of FLUSH-state cycles still owed, counting
  // the current one, so the redirect cycle plus FLUSH_CYC-1 FLUSH cycles
  // give exactly FLUSH_CYC flush cycles.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
    end else if (redirect_i) begin
      state_q     <= (FLUSH_CYC > 1) ? ST_FLUSH : ST_RUN;
      flush_cnt_q <= FLUSH_LOAD;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          flush_cnt_q <= flush_cnt_q - CNT_ONE;
          if (flush_cnt_q == CNT_ONE) begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q     <= ST_RUN;
          flush_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl: directed scenarios plus a
//            randomized run against a behavioural model that tracks issued
//            instructions by issue cycle and redirects by a flush deadline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int DEPTH     = 3;
  localparam int LOAD_LAT  = 1;
  localparam int FLUSH_CYC = 2;

  logic        clk = 1'b0;
  logic        nrst;
  logic        dec_valid;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_use_rs1, dec_use_rs2, dec_we, dec_load;
  logic        redirect;
  logic        stall_fe, bubble, flush_fe, issue;
  logic [31:0] stall_cnt;
  logic [3:0]  ctl;

  assign ctl = {stall_fe, bubble, flush_fe, issue};

  always #5 clk = ~clk;

  hazard_ctrl #(
    .DEPTH     (DEPTH),
    .LOAD_LAT  (LOAD_LAT),
    .FLUSH_CYC (FLUSH_CYC)
  ) dut (
    .clk_i         (clk),
    .nrst_i        (nrst),
    .dec_valid_i   (dec_valid),
    .dec_rs1_i     (dec_rs1),
    .dec_rs2_i     (dec_rs2),
    .dec_use_rs1_i (dec_use_rs1),
    .dec_use_rs2_i (dec_use_rs2),
    .dec_rd_i      (dec_rd),
    .dec_we_i      (dec_we),
    .dec_load_i    (dec_load),
    .redirect_i    (redirect),
    .stall_fe_o    (stall_fe),
    .bubble_o      (bubble),
    .flush_fe_o    (flush_fe),
    .issue_o       (issue),
    .stall_cnt_o   (stall_cnt)
  );

  int vectors = 0;
  int errors  = 0;

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int         cyc;
    logic [4:0] rd;
    bit         we;
    bit         load;
    bit         killed;
  } rec_t;

  rec_t        hist[$];
  int          now         = 0;
  int          flush_until = -1;
  logic [31:0] model_cnt   = '0;
  bit          exp_stall, exp_bubble, exp_flush, exp_issue;

  // An instruction issued in cycle c still has an unforwardable load
  // result in cycles c+1 .. c+LOAD_LAT.
  function automatic bit model_hit();
    for (int i = 0; i < hist.size(); i++) begin
      if (!hist[i].killed && hist[i].we && hist[i].load && hist[i].rd != 5'd0 &&
          (now - hist[i].cyc) <= LOAD_LAT &&
          ((dec_use_rs1 && dec_rs1 == hist[i].rd) ||
           (dec_use_rs2 && dec_rs2 == hist[i].rd)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_eval();
    exp_flush  = nrst && (redirect || now <= flush_until);
    exp_stall  = nrst && dec_valid && model_hit() && !exp_flush;
    exp_bubble = exp_stall || exp_flush;
    exp_issue  = dec_valid && !exp_stall && !exp_flush;
  endfunction

  function automatic void model_commit();
    rec_t r;
    if (!nrst) begin
      hist.delete();
      flush_until = -1;
      model_cnt   = '0;
    end else begin
      if (redirect) begin
        for (int i = 0; i < hist.size(); i++)
          if (hist[i].cyc == now - 1) hist[i].killed = 1'b1;
        flush_until = now + FLUSH_CYC - 1;
      end
      if (exp_issue) begin
        r.cyc = now; r.rd = dec_rd; r.we = dec_we; r.load = dec_load; r.killed = 1'b0;
        hist.push_back(r);
      end
      if (exp_stall && model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 32'd1;
    end
    now++;
    while (hist.size() > 0 && (now - hist[0].cyc) > DEPTH + 1) void'(hist.pop_front());
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2,
                       input bit u2, input int rd, input bit we, input bit ld,
                       input bit redir);
    dec_valid = v;   dec_rs1 = 5'(rs1); dec_use_rs1 = u1;
    dec_rs2 = 5'(rs2); dec_use_rs2 = u2; dec_rd = 5'(rd);
    dec_we = we;     dec_load = ld;     redirect = redir;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    nrst = 1'b0;
    drive(1, 5, 1, 5, 1, 5, 1, 1, 1);
    for (int c = 0; c < 3; c++) begin
      settle();
      vectors++;
      if (ctl !== 4'b0001) begin
        errors++;
        $display("FAIL reset_hold ctl cyc%0d: got %b want 0001", c, ctl);
      end
      tick();
    end
    nrst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    vectors++;
    if (ctl !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release ctl: got %b want 0000", ctl);
    end
    vectors++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %h want 00000000", stall_cnt);
    end
    for (int k = 0; k < DEPTH; k++) begin
      vectors++;
      if (dut.sb_q[k].v !== 1'b0) begin
        errors++;
        $display("FAIL reset_sb%0d_v: got %b want 0", k, dut.sb_q[k].v);
      end
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [31:0] cnt0;
    logic [3:0]  want [4] = '{4'b0001, 4'b1100, 4'b0001, 4'b0000};
    cnt0 = model_cnt;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0:       drive(1, 0, 0, 0, 0, 5, 1, 1, 0);   // lw x5
        1, 2:    drive(1, 5, 1, 7, 1, 6, 1, 0, 0);   // add x6,x5,x7
        default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      settle();
      vectors++;
      if (ctl !== want[c]) begin
        errors++;
        $display("FAIL load_use ctl cyc%0d: got %b want %b", c, ctl, want[c]);
      end
      tick();
    end
    vectors++;
    if (stall_cnt !== cnt0 + 32'd1) begin
      errors++;
      $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, cnt0 + 32'd1);
    end
  endtask

  task automatic test_x0_dontcare();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0:       drive(1, 0, 0, 0, 0, 0, 1, 1, 0);   // lw x0
        1:       drive(1, 0, 1, 0, 1, 1, 1, 0, 0);   // add x1,x0,x0
        2:       drive(1, 0, 0, 0, 0, 5, 1, 1, 0);   // lw x5
        default: drive(1, 3, 1, 5, 0, 8, 1, 0, 0);   // rs2=x5 unused
      endcase
      settle();
      vectors++;
      if (ctl !== 4'b0001) begin
        errors++;
        $display("FAIL x0_dontcare ctl cyc%0d: got %b want 0001", c, ctl);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    logic [3:0] want [4] = '{4'b0001, 4'b0110, 4'b0110, 4'b0001};
    for (int c = 0; c < 4; c++) begin
      drive(1, 1, 1, 2, 1, 9, 1, 0, c == 1);
      settle();
      vectors++;
      if (ctl !== want[c]) begin
        errors++;
        $display("FAIL redirect ctl cyc%0d: got %b want %b", c, ctl, want[c]);
      end
      tick();
      if (c == 1) begin
        for (int k = 0; k < 2; k++) begin
          vectors++;
          if (dut.sb_q[k].v !== 1'b0) begin
            errors++;
            $display("FAIL redirect_sb%0d_v: got %b want 0", k, dut.sb_q[k].v);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] want [4] = '{4'b0110, 4'b0110, 4'b0110, 4'b0001};
    for (int c = 0; c < 4; c++) begin
      drive(1, 1, 1, 2, 1, 9, 1, 0, c < 2);
      settle();
      vectors++;
      if (ctl !== want[c]) begin
        errors++;
        $display("FAIL back_to_back ctl cyc%0d: got %b want %b", c, ctl, want[c]);
      end
      tick();
    end
  endtask

  task automatic test_priority();
    logic [31:0] cnt0;
    logic [3:0]  want [3] = '{4'b0001, 4'b0110, 4'b0110};
    cnt0 = model_cnt;
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drive(1, 0, 0, 0, 0, 5, 1, 1, 0);       // lw x5
      else        drive(1, 5, 1, 7, 1, 6, 1, 0, c == 1);  // dependent add
      settle();
      vectors++;
      if (ctl !== want[c]) begin
        errors++;
        $display("FAIL priority ctl cyc%0d: got %b want %b", c, ctl, want[c]);
      end
      tick();
    end
    vectors++;
    if (stall_cnt !== cnt0) begin
      errors++;
      $display("FAIL priority_cnt: got %0d want %0d", stall_cnt, cnt0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      nrst = ($urandom_range(0, 63) != 0);
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 19) == 0);
      settle();
      vectors++;
      if (ctl !== {exp_stall, exp_bubble, exp_flush, exp_issue}) begin
        errors++;
        $display("FAIL random ctl cyc%0d: got %b want %b", c, ctl,
                 {exp_stall, exp_bubble, exp_flush, exp_issue});
      end
      vectors++;
      if (stall_cnt !== model_cnt) begin
        errors++;
        $display("FAIL random cnt cyc%0d: got %0d want %0d", c, stall_cnt, model_cnt);
      end
      tick();
    end
    nrst = 1'b1;
  endtask

  task automatic test_saturation();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    model_cnt = 32'hFFFF_FFFE;
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 3; c++) begin
        if (c == 0) drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
        else        drive(1, 5, 1, 7, 1, 6, 1, 0, 0);
        settle();
        tick();
      end
      vectors++;
      if (stall_cnt !== model_cnt) begin
        errors++;
        $display("FAIL saturate cnt step%0d: got %h want %h", s, stall_cnt, model_cnt);
      end
    end
    vectors++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL saturate_final: got %h want ffffffff", stall_cnt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    nrst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_load_use();
    test_x0_dontcare();
    test_redirect();
    test_back_to_back();
    test_priority();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the in-order RV32 core. It sits beside the instruction-decode stage and keeps a shift-register scoreboard of the instructions issued past decode. Each cycle it decides whether the decoded instruction issues, stalls (load-use hazard) or is flushed (taken branch/jump redirect). It drives the hold, bubble and kill controls of the frontend and decode pipe registers, and keeps a saturating stall counter for performance monitoring.

## Interface
Parameters:
- DEPTH, 3, scoreboard entries: stages between decode output and regfile writeback.
- LOAD_LAT, 1, number of youngest entries whose load result is not yet forwardable (1 ≤ LOAD_LAT ≤ DEPTH).
- FLUSH_CYC, 2, cycles flush_fe stays high per redirect (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- nrst  in  1  reset, synchronous, active-low (one clock; reset is synchronous and active-low).
- dec_valid  in  1  decode stage holds a valid instruction.
- dec_rs1, dec_rs2  in  5 each  source register addresses.
- dec_use_rs1, dec_use_rs2  in  1 each  operand actually read.
- dec_rd  in  5  destination address.
- dec_we  in  1  instruction writes the regfile.
- dec_load  in  1  instruction is a load.
- redirect  in  1  execute resolved a taken branch, jal or jalr this cycle.
- stall_fe  out  1  hold the PC, the frontend pipe and the decode pipe registers.
- bubble  out  1  inject a NOP into the issue pipe instead of the decoded instruction.
- flush_fe  out  1  invalidate the frontend and decode pipe register contents.
- issue  out  1  the decoded instruction advances this cycle.
- stall_cnt  out  32  saturating count of stall_fe cycles.

## Operation
- Scoreboard: entries sb[0..DEPTH-1], each {v, rd, we, load}. sb[0] is the youngest, just past decode.
- Every cycle the entries shift: sb[k+1] <= sb[k]. sb[DEPTH-1] is dropped.
- sb[0] <= {1, dec_rd, dec_we, dec_load} when issue=1. Otherwise sb[0] <= 0 (bubble).
- Hazard hit: for any k < LOAD_LAT, sb[k].v & sb[k].we & sb[k].load & sb[k].rd≠0 & ((dec_use_rs1 & dec_rs1==sb[k].rd) | (dec_use_rs2 & dec_rs2==sb[k].rd)).
- Register x0 never causes a hazard.
- Non-load results are assumed forwarded and never stall.
- FSM states:
  - RUN → FLUSH on redirect; counter loads FLUSH_CYC-1.
  - FLUSH: counter decrements each cycle. FLUSH → RUN when counter==0 and redirect=0.
  - A redirect while in FLUSH reloads the counter to FLUSH_CYC-1 and stays in FLUSH.
- flush_fe = redirect | (state==FLUSH).
- stall_fe = dec_valid & hit & ~flush_fe. Flush has priority over stall.
- bubble = stall_fe | flush_fe.
- issue = dec_valid & ~stall_fe & ~flush_fe.
- On the redirect cycle, sb[0] is additionally cleared (v=0), because it holds the wrong-path instruction younger than the branch.
- stall_cnt increments when stall_fe=1 and saturates at 0xFFFF_FFFF.

## Timing
- Reset (nrst=0 at an edge): all sb entries invalid, state RUN, counter 0, stall_cnt 0.
- During reset and the first cycle after it: stall_fe=0, flush_fe=0, bubble=0. issue follows dec_valid.
- Reset asserted mid-flush or mid-stall aborts the operation immediately at that edge.
- stall_fe, bubble, flush_fe and issue are combinational from current inputs and registered state. They act in the same cycle.
- Load-use penalty is LOAD_LAT stall cycles when the dependent instruction immediately follows the load, and zero once the load is LOAD_LAT or more entries old.
- Redirect penalty: flush_fe is high for exactly FLUSH_CYC consecutive cycles, counting the redirect cycle.
- Redirect and hit in the same cycle: stall_fe=0, flush_fe=1, and stall_cnt does not increment.
- dec_valid=0 never stalls. It produces a bubble in sb[0].

## Structure
- The shared core package holds:
  - the scoreboard entry struct;
  - the FSM state enum {RUN, FLUSH};
  - the NOP encoding constant used for the injected bubble.
- One sub-module, hazard_match: combinational compare of the two source operands against one scoreboard entry, instantiated LOAD_LAT times.
- The FSM, the shift register and the counter stay in hazard_ctrl.

## Test plan
- Reset hold: 3 cycles with nrst=0 while dec_valid=1 and redirect=1 → flush_fe=0, stall_fe=0, stall_cnt=0, all sb.v=0 after the release edge.
- Load-use: issue `lw x5`, then `add x6,x5,x7` (use_rs1=1) → stall_fe=1 and bubble=1 for exactly 1 cycle, then issue=1; stall_cnt=1.
- x0 and don't-care operands: `lw x0` followed by `add x1,x0,x0` → no stall. `lw x5` followed by an instruction with dec_rs2=5 and use_rs2=0 → no stall.
- Redirect: pulse redirect for 1 cycle → flush_fe high for 2 cycles, sb[0] cleared, issue=0 during both cycles.
- Back-to-back redirect: a second redirect in the second flush cycle → flush_fe high for 3 consecutive cycles in total.
- Priority and saturation: redirect together with a load-use hit → stall_fe=0, flush_fe=1, stall_cnt unchanged. Force stall_cnt to 0xFFFF_FFFE and apply 3 stall cycles → value holds at 0xFFFF_FFFF.
